vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Purpose  : VGA raster timing generator (pixel/line counters, registered
//            active-video, sync and line/frame pulses) plus a PS/2 scan-code
//            decoder whose arrow-key requests are committed to `direction`
//            only at frame start, so movement changes once per frame.
// Ports    : VGA_clk      pixel clock (sole clock)
//            reset        synchronous active-high reset
//            pix_en       pixel-advance enable
//            key_valid    strobe for a new scan-code byte on key_data
//            key_data     PS/2 scan-code byte
//            xCount       current pixel column
//            yCount       current line
//            displayArea  registered active-video flag (blank_n is a copy)
//            VGA_hSync    horizontal sync, asserted level HS_POL
//            VGA_vSync    vertical sync, asserted level VS_POL
//            line_start   one-clock pulse at each line start
//            frame_start  one-clock pulse at each frame start
//            direction    committed movement code
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   CW         = 10,
  parameter logic NO_REVERSE = 1'b1
) (
  input  logic          VGA_clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          key_valid,
  input  logic [7:0]    key_data,
  output logic [CW-1:0] xCount,
  output logic [CW-1:0] yCount,
  output logic          displayArea,
  output logic          blank_n,
  output logic          VGA_hSync,
  output logic          VGA_vSync,
  output logic          line_start,
  output logic          frame_start,
  output logic [2:0]    direction
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] ONE      = CW'(1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      xCount <= '0;
      yCount <= '0;
    end else if (pix_en) begin
      if (xCount == H_LAST) begin
        xCount <= '0;
        yCount <= (yCount == V_LAST) ? '0 : yCount + ONE;
      end else begin
        xCount <= xCount + ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered timing outputs: all decoded from the counter values of the
  // previous clock, so they trail xCount/yCount by exactly one cycle.
  // --------------------------------------------------------------------------
  logic hs_active;
  logic vs_active;
  logic at_origin;
  logic commit;

  assign hs_active = (xCount >= HS_BEGIN) && (xCount < HS_END);
  assign vs_active = (yCount >= VS_BEGIN) && (yCount < VS_END);
  assign at_origin = (xCount == '0) && (yCount == '0);
  // Direction commits on the same edge that raises frame_start.
  assign commit    = pix_en && at_origin;

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      displayArea <= 1'b0;
      VGA_hSync   <= ~HS_POL;
      VGA_vSync   <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      displayArea <= (xCount < H_ACT) && (yCount < V_ACT);
      VGA_hSync   <= hs_active ? HS_POL : ~HS_POL;
      VGA_vSync   <= vs_active ? VS_POL : ~VS_POL;
      line_start  <= pix_en && (xCount == '0);
      frame_start <= commit;
    end
  end

  assign blank_n = displayArea;

  // --------------------------------------------------------------------------
  // Scan-code decoder
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       req;
  logic [2:0] arrow_dir;

  always_comb begin
    arrow_dir = 3'b000;
    case (key_data)
      CODE_UP:    arrow_dir = 3'b001;
      CODE_LEFT:  arrow_dir = 3'b010;
      CODE_DOWN:  arrow_dir = 3'b011;
      CODE_RIGHT: arrow_dir = 3'b100;
      default:    arrow_dir = 3'b000;
    endcase
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    if (key_valid) begin
      case (state)
        S_IDLE: begin
          if (key_data == CODE_EXT)      state_next = S_EXT;
          else if (key_data == CODE_BRK) state_next = S_BRK;
          else begin
            state_next = S_IDLE;
            req        = (arrow_dir != 3'b000);
          end
        end
        S_EXT: begin
          if (key_data == CODE_BRK) state_next = S_EXT_BRK;
          else begin
            state_next = S_IDLE;
            req        = (arrow_dir != 3'b000);
          end
        end
        // Byte following a break prefix is a key release: swallow it.
        S_BRK:     state_next = S_IDLE;
        S_EXT_BRK: state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pending request and committed direction
  // --------------------------------------------------------------------------
  logic       pend_valid;
  logic [2:0] pend_dir;
  logic       reversal;

  // up<->down and left<->right are the only opposing pairs.
  assign reversal = ((direction == 3'b001) && (pend_dir == 3'b011)) ||
                    ((direction == 3'b011) && (pend_dir == 3'b001)) ||
                    ((direction == 3'b010) && (pend_dir == 3'b100)) ||
                    ((direction == 3'b100) && (pend_dir == 3'b010));

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      direction  <= 3'b000;
      pend_valid <= 1'b0;
      pend_dir   <= 3'b000;
    end else begin
      // Commit uses the pending value held before this edge; a request
      // arriving on the same edge becomes the next pending value.
      if (commit && pend_valid && !(NO_REVERSE && reversal))
        direction <= pend_dir;
      if (req) begin
        pend_valid <= 1'b1;
        pend_dir   <= arrow_dir;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Purpose  : Self-checking bench for vga_timing_ctrl using a reduced raster
//            (15 x 10) and two instances differing in sync polarity and
//            reversal policy, compared every clock against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;

  logic [CW-1:0] x0, y0, x1, y1;
  logic disp0, blank0, hs0, vs0, ls0, fs0;
  logic disp1, blank1, hs1, vs1, ls1, fs1;
  logic [2:0] dir0, dir1;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .NO_REVERSE(1'b1)
  ) dut0 (
    .VGA_clk(clk), .reset(reset), .pix_en(pix_en), .key_valid(key_valid),
    .key_data(key_data), .xCount(x0), .yCount(y0), .displayArea(disp0),
    .blank_n(blank0), .VGA_hSync(hs0), .VGA_vSync(vs0), .line_start(ls0),
    .frame_start(fs0), .direction(dir0)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .NO_REVERSE(1'b0)
  ) dut1 (
    .VGA_clk(clk), .reset(reset), .pix_en(pix_en), .key_valid(key_valid),
    .key_data(key_data), .xCount(x1), .yCount(y1), .displayArea(disp1),
    .blank_n(blank1), .VGA_hSync(hs1), .VGA_vSync(vs1), .line_start(ls1),
    .frame_start(fs1), .direction(dir1)
  );

  // Reference model: raster position as (mx,my), registered flags as
  // expected values, scan codes interpreted as whole byte sequences.
  int         mx, my;
  bit         e_disp, e_hs, e_vs, e_ls, e_fs;
  logic [2:0] e_dir0, e_dir1;
  bit         pend_v;
  logic [2:0] pend;
  logic [7:0] seq[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [2:0] arrow(input logic [7:0] b);
    case (b)
      8'h75:   return 3'b001;
      8'h6B:   return 3'b010;
      8'h72:   return 3'b011;
      8'h74:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit opposite(input logic [2:0] a, input logic [2:0] b);
    return (a != 0) && (b != 0) && (a != b) &&
           ((a == 3'b001 && b == 3'b011) || (a == 3'b011 && b == 3'b001) ||
            (a == 3'b010 && b == 3'b100) || (a == 3'b100 && b == 3'b010));
  endfunction

  task automatic model_clock();
    int lin;
    if (reset) begin
      mx = 0; my = 0;
      e_disp = 0; e_hs = 0; e_vs = 0; e_ls = 0; e_fs = 0;
      e_dir0 = 0; e_dir1 = 0; pend_v = 0; pend = 0;
      seq.delete();
    end else begin
      e_disp = (mx < HA) && (my < VA);
      e_hs   = (mx >= HA + HF) && (mx < HA + HF + HS);
      e_vs   = (my >= VA + VF) && (my < VA + VF + VS);
      e_ls   = pix_en && (mx == 0);
      e_fs   = pix_en && (mx == 0) && (my == 0);
      if (e_fs && pend_v) begin
        if (!opposite(e_dir0, pend)) e_dir0 = pend;
        e_dir1 = pend;
        pend_v = 0;
      end
      if (key_valid) begin
        seq.push_back(key_data);
        if (seq.size() == 1 && (seq[0] == 8'hE0 || seq[0] == 8'hF0)) begin
          // prefix still open
        end else if (seq.size() == 2 && seq[0] == 8'hE0 && seq[1] == 8'hF0) begin
          // extended break prefix still open
        end else begin
          if ((seq.size() == 1 || (seq.size() == 2 && seq[0] == 8'hE0)) &&
              arrow(seq[seq.size()-1]) != 0) begin
            pend_v = 1;
            pend   = arrow(seq[seq.size()-1]);
          end
          seq.delete();
        end
      end
      if (pix_en) begin
        lin = (my * HT + mx + 1) % (HT * VT);
        mx  = lin % HT;
        my  = lin / HT;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("xCount",       32'(x0),    32'(mx));
    chk("yCount",       32'(y0),    32'(my));
    chk("displayArea",  32'(disp0), 32'(e_disp));
    chk("blank_n",      32'(blank0),32'(e_disp));
    chk("hsync_pol0",   32'(hs0),   32'(e_hs ? 1'b0 : 1'b1));
    chk("vsync_pol0",   32'(vs0),   32'(e_vs ? 1'b0 : 1'b1));
    chk("line_start",   32'(ls0),   32'(e_ls));
    chk("frame_start",  32'(fs0),   32'(e_fs));
    chk("direction_nr1",32'(dir0),  32'(e_dir0));
    chk("hsync_pol1",   32'(hs1),   32'(e_hs ? 1'b1 : 1'b0));
    chk("vsync_pol1",   32'(vs1),   32'(e_vs ? 1'b1 : 1'b0));
    chk("direction_nr0",32'(dir1),  32'(e_dir1));
    chk("xCount_dut1",  32'(x1),    32'(mx));
    chk("fs_dut1",      32'(fs1),   32'(e_fs));
  endtask

  task automatic step(input bit r, input bit pe, input bit kv, input logic [7:0] kd);
    reset = r; pix_en = pe; key_valid = kv; key_data = kd;
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit pe);
    for (int i = 0; i < n; i++) step(1'b0, pe, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, 1'b1, b);
    idle(2, 1'b1);
  endtask

  // Advance until the next edge will be a commit edge (counters at origin).
  task automatic to_origin();
    for (int i = 0; i < 2 * HT * VT && !(mx == 0 && my == 0); i++)
      idle(1, 1'b1);
  endtask

  task automatic through_frame();
    to_origin();
    idle(3, 1'b1);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 7))
      0, 1:    return 8'hE0;
      2:       return 8'hF0;
      3:       return 8'h75;
      4:       return 8'h6B;
      5:       return 8'h72;
      6:       return 8'h74;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    step(1'b1, 1'b1, 1'b1, 8'h75);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    // First enabled cycle after release, then two full frames
    idle(2 * HT * VT + 5, 1'b1);
    // Alternating pixel enable: every period doubles
    for (int i = 0; i < 2 * HT * VT; i++) idle(1, (i % 2) == 0);

    // Extended up arrow mid-frame commits at the next frame start
    idle(40, 1'b1);
    send(8'hE0); send(8'h75);
    through_frame();
    // Extended release of up: no change
    send(8'hE0); send(8'hF0); send(8'h75);
    through_frame();
    // Down while moving up: rejected by dut0, accepted by dut1
    send(8'h72);
    through_frame();
    through_frame();
    // Last request in a frame wins
    send(8'h6B); send(8'h74);
    through_frame();
    // Key byte on the commit edge: commit uses older pending (left)
    send(8'h6B);
    to_origin();
    step(1'b0, 1'b1, 1'b1, 8'h75);
    idle(2, 1'b1);
    through_frame();

    // Reset mid-frame while the decoder is in the extended state
    send(8'hE0);
    for (int i = 0; i < 2 * HT * VT && !(mx == HA + HF + HS && my == VA); i++)
      idle(1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h75);
    send(8'h75);
    through_frame();

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, pick_byte());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
